// File: rtl/tx_packet_enqueue_if.sv
// Bundles the client packet bus and the TX data FIFO write port.
// The master side is the packet source / FIFO environment; the slave side is the enqueue stage.
interface tx_packet_enqueue_if;
    // client packet bus
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_val;
    logic        pkt_tx_sop;
    logic        pkt_tx_eop;
    logic [2:0]  pkt_tx_mod;
    logic        pkt_tx_full;
    // TX data FIFO write port
    logic        txdfifo_wfull;
    logic        txdfifo_walmost_full;
    logic [63:0] txdfifo_wdata;
    logic [7:0]  txdfifo_wstatus;
    logic        txdfifo_wen;

    modport master (
        output pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
        input  pkt_tx_full,
        output txdfifo_wfull, txdfifo_walmost_full,
        input  txdfifo_wdata, txdfifo_wstatus, txdfifo_wen
    );

    modport slave (
        input  pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
        output pkt_tx_full,
        input  txdfifo_wfull, txdfifo_walmost_full,
        output txdfifo_wdata, txdfifo_wstatus, txdfifo_wen
    );
endinterface

// File: rtl/tx_packet_enqueue.sv
// 10GE MAC TX packet write stage: checks SOP/EOP framing, pads runts to the
// minimum frame length, flags oversize frames and writes word + status into the TX data FIFO.
module tx_packet_enqueue #(
    parameter int MAX_BYTES = 1518,
    parameter int MIN_BYTES = 60
) (
    input  logic               clk_156m25,
    input  logic               reset_156m25,
    tx_packet_enqueue_if.slave bus,
    output logic               status_tx_proto_err,
    input  logic               status_clear
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;

    localparam logic [14:0] MIN_TOTAL     = 15'(MIN_BYTES);
    localparam logic [14:0] MAX_TOTAL     = 15'(MAX_BYTES);
    // byte count in front of the 8th (last padded) word of a minimum-length frame
    localparam logic [13:0] LAST_WORD_CNT = 14'((MIN_BYTES / 8) * 8);
    localparam logic [13:0] CNT_SAT       = 14'h3FFF;

    logic [1:0]  state, state_d;
    logic [13:0] byte_cnt, byte_cnt_d;
    logic        wen_d;
    logic [63:0] wdata_d;
    logic [7:0]  wstatus_d;
    logic        proto_err_set;
    logic        accept;
    logic        eop_path;
    logic        eop_sop;
    logic [13:0] base_cnt;
    logic [3:0]  mod_bytes;
    logic [14:0] total;
    logic [63:0] masked_data;

    // PAD owns the FIFO write port, so the client is held off for its duration.
    assign bus.pkt_tx_full = bus.txdfifo_walmost_full | bus.txdfifo_wfull | (state == ST_PAD);
    assign accept          = bus.pkt_tx_val & ~bus.pkt_tx_full;

    // A SOP+EOP word in IDLE starts from zero bytes; otherwise continue the running count.
    assign base_cnt  = (state == ST_IDLE) ? 14'd0 : byte_cnt;
    assign mod_bytes = (bus.pkt_tx_mod == 3'd0) ? 4'd8 : {1'b0, bus.pkt_tx_mod};
    assign total     = {1'b0, base_cnt} + {11'd0, mod_bytes};

    // Zero the bytes of the EOP word that lie beyond pkt_tx_mod.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        masked_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (bus.pkt_tx_mod == 3'd0 || 3'(i) < bus.pkt_tx_mod)
                masked_data[8*i +: 8] = bus.pkt_tx_data[8*i +: 8];
        end
    end

    // Next-state, byte counter and FIFO write word for this cycle.
    always_comb begin
        state_d       = state;
        byte_cnt_d    = byte_cnt;
        wen_d         = 1'b0;
        wdata_d       = '0;
        wstatus_d     = '0;
        proto_err_set = 1'b0;
        eop_path      = 1'b0;
        eop_sop       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.pkt_tx_sop) begin
                        if (bus.pkt_tx_eop) begin
                            eop_path = 1'b1;
                            eop_sop  = 1'b1;
                        end else begin
                            wen_d      = 1'b1;
                            wdata_d    = bus.pkt_tx_data;
                            wstatus_d  = 8'h80;
                            byte_cnt_d = 14'd8;
                            state_d    = ST_FRAME;
                        end
                    end else begin
                        // word outside a frame: dropped
                        proto_err_set = 1'b1;
                    end
                end
            end

            ST_FRAME: begin
                if (accept) begin
                    if (bus.pkt_tx_sop) begin
                        // missing EOP: close the open frame as errored; the new frame is lost
                        wen_d         = 1'b1;
                        wdata_d       = bus.pkt_tx_data;
                        wstatus_d     = 8'hE0;
                        proto_err_set = 1'b1;
                        byte_cnt_d    = '0;
                        state_d       = ST_IDLE;
                    end else if (bus.pkt_tx_eop) begin
                        eop_path = 1'b1;
                    end else begin
                        wen_d      = 1'b1;
                        wdata_d    = bus.pkt_tx_data;
                        byte_cnt_d = (byte_cnt > CNT_SAT - 14'd8) ? CNT_SAT : byte_cnt + 14'd8;
                    end
                end
            end

            ST_PAD: begin
                if (~bus.txdfifo_walmost_full & ~bus.txdfifo_wfull) begin
                    wen_d = 1'b1;
                    if (byte_cnt == LAST_WORD_CNT) begin
                        wstatus_d  = 8'h44;
                        byte_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt + 14'd8;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // EOP word: terminate normally, terminate inside the last padded word, or start padding.
        if (eop_path) begin
            wen_d = 1'b1;
            if (total >= MIN_TOTAL) begin
                wdata_d    = bus.pkt_tx_data;
                wstatus_d  = {eop_sop, 1'b1, total > MAX_TOTAL, 2'b00, bus.pkt_tx_mod};
                byte_cnt_d = '0;
                state_d    = ST_IDLE;
            end else if (base_cnt == LAST_WORD_CNT) begin
                wdata_d    = masked_data;
                wstatus_d  = {eop_sop, 1'b1, 1'b0, 2'b00, 3'd4};
                byte_cnt_d = '0;
                state_d    = ST_IDLE;
            end else begin
                wdata_d    = masked_data;
                wstatus_d  = {eop_sop, 7'd0};
                byte_cnt_d = base_cnt + 14'd8;
                state_d    = ST_PAD;
            end
        end
    end

    // Registered state, counter, FIFO write port and sticky framing-error flag.
    always_ff @(posedge clk_156m25) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_156m25) begin
            state               <= ST_IDLE;
            byte_cnt            <= '0;
            bus.txdfifo_wen     <= 1'b0;
            bus.txdfifo_wdata   <= '0;
            bus.txdfifo_wstatus <= '0;
            status_tx_proto_err <= 1'b0;
        end else begin
            state               <= state_d;
            byte_cnt            <= byte_cnt_d;
            bus.txdfifo_wen     <= wen_d;
            bus.txdfifo_wdata   <= wdata_d;
            bus.txdfifo_wstatus <= wstatus_d;
            if (proto_err_set)
                status_tx_proto_err <= 1'b1;
            else if (status_clear)
                status_tx_proto_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_packet_enqueue.sv
// Self-checking bench for tx_packet_enqueue: expected FIFO writes are queued as
// words are accepted and compared in order as the DUT writes them.
module tb_tx_packet_enqueue;

    localparam int MAX_BYTES = 1518;

    logic clk_156m25 = 1'b0;
    logic reset_156m25;
    logic status_clear;
    logic status_tx_proto_err;

    tx_packet_enqueue_if bus ();

    tx_packet_enqueue #(.MAX_BYTES(MAX_BYTES), .MIN_BYTES(60)) dut (
        .clk_156m25          (clk_156m25),
        .reset_156m25        (reset_156m25),
        .bus                 (bus),
        .status_tx_proto_err (status_tx_proto_err),
        .status_clear        (status_clear)
    );

    always #5 clk_156m25 = ~clk_156m25;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  status;
        bit          chk_data;
        int          cyc;      // -1: any cycle
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_writes = 0;

    always @(posedge clk_156m25) cyc <= cyc + 1;

    // Scoreboard: every FIFO write must match the oldest outstanding expectation.
    always @(negedge clk_156m25) begin
        if (bus.txdfifo_wen === 1'b1) begin
            n_writes++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got data=%h status=%h at cycle %0d, required no write",
                         bus.txdfifo_wdata, bus.txdfifo_wstatus, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.txdfifo_wstatus !== mon_e.status ||
                    (mon_e.chk_data && bus.txdfifo_wdata !== mon_e.data) ||
                    (mon_e.cyc >= 0 && cyc != mon_e.cyc))
                    $display("FAIL write_%0d: got data=%h status=%h cycle=%0d, required data=%h status=%h cycle=%0d",
                             n_writes, bus.txdfifo_wdata, bus.txdfifo_wstatus, cyc,
                             mon_e.data, mon_e.status, mon_e.cyc);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic logic [63:0] word_data(input logic [7:0] seed, input int k);
        logic [7:0]  kb  = 8'(k);
        logic [15:0] mid = 16'hA5C3 ^ 16'(k * 37);
        logic [23:0] low = 24'(k * 7919 + 1);
        return {seed, kb, mid, seed ^ 8'h5A, low};
    endfunction

    function automatic logic [63:0] low_bytes(input logic [63:0] d, input int n);
        logic [63:0] r = d;
        for (int b = n; b < 8; b++) r[8*b +: 8] = 8'h00;
        return r;
    endfunction

    task automatic idle();
        bus.pkt_tx_val = 1'b0;
        bus.pkt_tx_sop = 1'b0;
        bus.pkt_tx_eop = 1'b0;
        bus.pkt_tx_mod = 3'd0;
    endtask

    // Drive one word at a negedge, wait (bounded) for acceptance, queue its expected write.
    task automatic send_word(input logic [63:0] d, input logic s, input logic e, input logic [2:0] m,
                             input bit push, input logic [7:0] est, input logic [63:0] ed,
                             input bit chk, output bit ok);
        int   g = 0;
        exp_t x;
        bus.pkt_tx_data = d;
        bus.pkt_tx_val  = 1'b1;
        bus.pkt_tx_sop  = s;
        bus.pkt_tx_eop  = e;
        bus.pkt_tx_mod  = m;
        #1;
        while (bus.pkt_tx_full !== 1'b0 && g < 200) begin
            @(negedge clk_156m25);
            #1;
            g++;
        end
        ok = (bus.pkt_tx_full === 1'b0);
        if (!ok) begin
            idle();
            return;
        end
        if (push) begin
            x.data = ed; x.status = est; x.chk_data = chk; x.cyc = cyc + 1;
            exp_q.push_back(x);
        end
        @(posedge clk_156m25);
        @(negedge clk_156m25);
    endtask

    // Send a whole frame; expectations come from a frame-level reference of framing/padding.
    task automatic send_frame(input int nwords, input logic [2:0] lastmod, input logic [7:0] seed,
                              output bit ok);
        int          bytes;
        int          nlast;
        logic [7:0]  st;
        logic [63:0] d, ed;
        bit          w_ok;
        exp_t        x;
        ok    = 1'b1;
        nlast = (lastmod == 3'd0) ? 8 : int'(lastmod);
        bytes = (nwords - 1) * 8 + nlast;
        for (int k = 0; k < nwords; k++) begin
            d  = word_data(seed, k);
            ed = d;
            st = (k == 0) ? 8'h80 : 8'h00;
            if (k == nwords - 1) begin
                if (bytes >= 60) begin
                    st[6]   = 1'b1;
                    st[5]   = (bytes > MAX_BYTES);
                    st[2:0] = lastmod;
                end else begin
                    ed = low_bytes(d, nlast);
                    if (nwords == 8) begin
                        st[6]   = 1'b1;
                        st[2:0] = 3'd4;
                    end
                end
            end
            send_word(d, k == 0, k == nwords - 1, (k == nwords - 1) ? lastmod : 3'd0,
                      1'b1, st, ed, 1'b1, w_ok);
            if (!w_ok) begin
                ok = 1'b0;
                break;
            end
        end
        idle();
        if (ok && bytes < 60 && nwords < 8) begin
            for (int k = nwords; k < 8; k++) begin
                x.data = '0; x.status = (k == 7) ? 8'h44 : 8'h00; x.chk_data = 1'b1; x.cyc = -1;
                exp_q.push_back(x);
            end
        end
    endtask

    // Wait (bounded) for all expected writes, then a few idle cycles to catch stray writes.
    task automatic wait_drain(output bit ok);
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk_156m25);
            g++;
        end
        ok = (exp_q.size() == 0);
        repeat (4) @(negedge clk_156m25);
        if (!ok) exp_q.delete();
    endtask

    task automatic test_reset();
        reset_156m25             = 1'b1;
        status_clear             = 1'b0;
        bus.txdfifo_wfull        = 1'b0;
        bus.txdfifo_walmost_full = 1'b0;
        bus.pkt_tx_data          = '0;
        idle();
        repeat (3) @(negedge clk_156m25);
        n_checks++;
        if (bus.txdfifo_wen === 1'b0) n_pass++;
        else $display("FAIL reset_wen: got %b, required 0", bus.txdfifo_wen);
        n_checks++;
        if (bus.txdfifo_wdata === 64'd0) n_pass++;
        else $display("FAIL reset_wdata: got %h, required 0", bus.txdfifo_wdata);
        n_checks++;
        if (bus.txdfifo_wstatus === 8'd0) n_pass++;
        else $display("FAIL reset_wstatus: got %h, required 00", bus.txdfifo_wstatus);
        n_checks++;
        if (status_tx_proto_err === 1'b0) n_pass++;
        else $display("FAIL reset_proto_err: got %b, required 0", status_tx_proto_err);
        n_checks++;
        if (bus.pkt_tx_full === 1'b0) n_pass++;
        else $display("FAIL reset_full: got %b, required 0", bus.pkt_tx_full);
        bus.txdfifo_walmost_full = 1'b1;
        #1;
        n_checks++;
        if (bus.pkt_tx_full === 1'b1) n_pass++;
        else $display("FAIL full_follows_almost_full: got %b, required 1", bus.pkt_tx_full);
        bus.txdfifo_walmost_full = 1'b0;
        @(negedge clk_156m25);
        reset_156m25 = 1'b0;
        @(negedge clk_156m25);
    endtask

    task automatic test_normal_frame();
        bit s_ok, d_ok;
        send_frame(8, 3'd0, 8'h11, s_ok);
        wait_drain(d_ok);
        n_checks++;
        if (s_ok && d_ok) n_pass++;
        else $display("FAIL normal_frame_done: sent=%0b drained=%0b, required 1/1", s_ok, d_ok);
    endtask

    task automatic test_runt();
        bit s_ok, d_ok;
        int full_cnt = 0;
        send_frame(2, 3'd3, 8'h22, s_ok);
        for (int i = 0; i < 10; i++) begin
            if (bus.pkt_tx_full === 1'b1) full_cnt++;
            @(negedge clk_156m25);
        end
        wait_drain(d_ok);
        n_checks++;
        if (full_cnt == 6) n_pass++;
        else $display("FAIL runt_pad_full_cycles: got %0d, required 6", full_cnt);
        n_checks++;
        if (s_ok && d_ok) n_pass++;
        else $display("FAIL runt_done: sent=%0b drained=%0b, required 1/1", s_ok, d_ok);
        send_frame(1, 3'd5, 8'h23, s_ok);
        wait_drain(d_ok);
        n_checks++;
        if (s_ok && d_ok) n_pass++;
        else $display("FAIL single_word_runt_done: sent=%0b drained=%0b, required 1/1", s_ok, d_ok);
    endtask

    task automatic test_length_limits();
        int         nw_tab[5] = '{190, 191, 8, 8, 7};
        logic [2:0] md_tab[5] = '{3'd6, 3'd0, 3'd2, 3'd4, 3'd0};
        bit         s_ok, d_ok;
        for (int i = 0; i < 5; i++) begin
            send_frame(nw_tab[i], md_tab[i], 8'h30 + 8'(i), s_ok);
            wait_drain(d_ok);
            n_checks++;
            if (s_ok && d_ok) n_pass++;
            else $display("FAIL length_case_%0d_done: sent=%0b drained=%0b, required 1/1", i, s_ok, d_ok);
        end
    endtask

    task automatic test_back_to_back();
        bit s1, s2, d_ok;
        send_frame(9, 3'd0, 8'h41, s1);
        send_frame(9, 3'd7, 8'h42, s2);
        wait_drain(d_ok);
        n_checks++;
        if (s1 && s2 && d_ok) n_pass++;
        else $display("FAIL back_to_back_done: sent=%0b%0b drained=%0b, required 11/1", s1, s2, d_ok);
    endtask

    task automatic test_framing_errors();
        bit w_ok, d_ok;
        send_word(word_data(8'h50, 0), 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, '0, 1'b0, w_ok);
        idle();
        n_checks++;
        if (w_ok && status_tx_proto_err === 1'b1) n_pass++;
        else $display("FAIL stray_word_sets_err: got %b, required 1", status_tx_proto_err);
        status_clear = 1'b1;
        @(negedge clk_156m25);
        status_clear = 1'b0;
        n_checks++;
        if (status_tx_proto_err === 1'b0) n_pass++;
        else $display("FAIL status_clear: got %b, required 0", status_tx_proto_err);

        send_word(word_data(8'h51, 0), 1'b1, 1'b0, 3'd0, 1'b1, 8'h80, word_data(8'h51, 0), 1'b1, w_ok);
        send_word(word_data(8'h51, 1), 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, word_data(8'h51, 1), 1'b1, w_ok);
        send_word(word_data(8'h52, 0), 1'b1, 1'b0, 3'd0, 1'b1, 8'hE0, '0, 1'b0, w_ok);
        idle();
        n_checks++;
        if (status_tx_proto_err === 1'b1) n_pass++;
        else $display("FAIL mid_frame_sop_sets_err: got %b, required 1", status_tx_proto_err);

        status_clear = 1'b1;
        send_word(word_data(8'h53, 0), 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, '0, 1'b0, w_ok);
        status_clear = 1'b0;
        idle();
        n_checks++;
        if (status_tx_proto_err === 1'b1) n_pass++;
        else $display("FAIL set_beats_clear: got %b, required 1", status_tx_proto_err);
        status_clear = 1'b1;
        @(negedge clk_156m25);
        status_clear = 1'b0;
        n_checks++;
        if (status_tx_proto_err === 1'b0) n_pass++;
        else $display("FAIL second_clear: got %b, required 0", status_tx_proto_err);
        wait_drain(d_ok);
        n_checks++;
        if (d_ok) n_pass++;
        else $display("FAIL framing_errors_done: drained=%0b, required 1", d_ok);
    endtask

    task automatic test_backpressure();
        bit s_ok, d_ok;
        send_frame(2, 3'd3, 8'h61, s_ok);
        bus.txdfifo_walmost_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_156m25);
            n_checks++;
            if (bus.txdfifo_wen === 1'b0) n_pass++;
            else $display("FAIL pad_paused_cycle_%0d: got wen=%b, required 0", i, bus.txdfifo_wen);
        end
        bus.txdfifo_walmost_full = 1'b0;
        wait_drain(d_ok);
        n_checks++;
        if (s_ok && d_ok) n_pass++;
        else $display("FAIL pad_resume_done: sent=%0b drained=%0b, required 1/1", s_ok, d_ok);

        bus.txdfifo_wfull = 1'b1;
        fork
            send_frame(8, 3'd0, 8'h62, s_ok);
            begin
                repeat (3) @(negedge clk_156m25);
                bus.txdfifo_wfull = 1'b0;
            end
        join
        wait_drain(d_ok);
        n_checks++;
        if (s_ok && d_ok) n_pass++;
        else $display("FAIL wfull_hold_done: sent=%0b drained=%0b, required 1/1", s_ok, d_ok);
    endtask

    task automatic test_reset_mid_frame();
        bit w_ok, d_ok;
        for (int k = 0; k < 3; k++)
            send_word(word_data(8'h71, k), k == 0, 1'b0, 3'd0, 1'b1,
                      (k == 0) ? 8'h80 : 8'h00, word_data(8'h71, k), 1'b1, w_ok);
        idle();
        reset_156m25 = 1'b1;
        @(negedge clk_156m25);
        n_checks++;
        if (bus.txdfifo_wen === 1'b0 && bus.txdfifo_wdata === 64'd0 && bus.txdfifo_wstatus === 8'd0) n_pass++;
        else $display("FAIL reset_mid_frame_outputs: got wen=%b data=%h status=%h, required 0/0/00",
                      bus.txdfifo_wen, bus.txdfifo_wdata, bus.txdfifo_wstatus);
        reset_156m25 = 1'b0;
        @(negedge clk_156m25);
        send_word(word_data(8'h72, 3), 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, '0, 1'b0, w_ok);
        idle();
        n_checks++;
        if (w_ok && status_tx_proto_err === 1'b1) n_pass++;
        else $display("FAIL post_reset_stray_err: got %b, required 1", status_tx_proto_err);
        wait_drain(d_ok);
        n_checks++;
        if (d_ok) n_pass++;
        else $display("FAIL reset_mid_frame_done: drained=%0b, required 1", d_ok);
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_runt();
        test_length_limits();
        test_back_to_back();
        test_framing_errors();
        test_backpressure();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
